// File: rtl/core_ex_muldiv.sv
// Iterative multiply/divide unit for EX. It owns HI/LO, runs MULT/MULTU/DIV/DIVU on
// operand magnitudes over XLEN/STEPS_PER_CYCLE cycles, and then applies the sign fix.
//
//   state  | meaning
//   IDLE   | no operation; MTHI/MTLO writes accepted; hi/lo readable without stall
//   RUN    | STEPS_PER_CYCLE shift-add / restoring shift-subtract steps per cycle
//   FIX    | sign correction; hi/lo written at exit edge, done pulses next cycle
module core_ex_muldiv #(
  parameter int XLEN            = 64,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            mf_req,
  input  logic            mt_hi,
  input  logic            mt_lo,
  input  logic [XLEN-1:0] mt_data,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done,
  output logic            stall
);

  localparam int ITERS = XLEN / STEPS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e              state_q, state_d;
  logic                is_div_q, is_div_d;
  logic                neg_a_q, neg_a_d;
  logic                neg_b_q, neg_b_d;
  logic [XLEN-1:0]     mag_a_q, mag_a_d;
  logic [XLEN-1:0]     mag_b_q, mag_b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     hi_q, hi_d;
  logic [XLEN-1:0]     lo_q, lo_d;
  logic                done_q, done_d;

  logic                in_signed;
  logic [XLEN-1:0]     in_mag_a, in_mag_b;
  logic [2*XLEN-1:0]   acc_step;
  logic [XLEN:0]       sum;
  logic [XLEN:0]       trial;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     hi_res, lo_res;

  // op encoding: bit 1 selects divide, bit 0 selects unsigned
  always_comb begin
    in_signed = ~op[0];
    in_mag_a  = (in_signed && A[XLEN-1]) ? -A : A;
    in_mag_b  = (in_signed && B[XLEN-1]) ? -B : B;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    acc_step = acc_q;
    sum      = '0;
    trial    = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (!is_div_q) begin
        sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, mag_a_q} : '0);
        acc_step = {sum, acc_step[XLEN-1:1]};
      end else begin
        trial = acc_step[2*XLEN-1:XLEN-1] - {1'b0, mag_b_q};
        if (!trial[XLEN]) acc_step = {trial[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
        else              acc_step = {acc_step[2*XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    if (!is_div_q) begin
      hi_res = prod_fix[2*XLEN-1:XLEN];
      lo_res = prod_fix[XLEN-1:0];
    end else if (mag_b_q == '0) begin
      // divide by zero returns the original dividend, rebuilt from magnitude and sign
      lo_res = '1;
      hi_res = neg_a_q ? -mag_a_q : mag_a_q;
    end else begin
      lo_res = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      hi_res = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!flush) begin
          if (start) begin
            state_d  = S_RUN;
            is_div_d = op[1];
            neg_a_d  = in_signed & A[XLEN-1];
            neg_b_d  = in_signed & B[XLEN-1];
            mag_a_d  = in_mag_a;
            mag_b_d  = in_mag_b;
            cnt_d    = '0;
            acc_d    = op[1] ? {{XLEN{1'b0}}, in_mag_a} : {{XLEN{1'b0}}, in_mag_b};
          end else begin
            if (mt_hi) hi_d = mt_data;
            if (mt_lo) lo_d = mt_data;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          hi_d   = hi_res;
          lo_d   = lo_res;
          done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != S_IDLE);
  assign done  = done_q;
  assign stall = busy && (start || mf_req || mt_hi || mt_lo);

endmodule

// File: tb/tb_core_ex_muldiv.sv
// Directed bench for core_ex_muldiv: vector table of mul/div results plus
// hand-written interlock, flush and reset sequences.
module tb_core_ex_muldiv;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MNEG = 64'h8000_0000_0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [63:0] A     = '0;
  logic [63:0] B     = '0;
  logic        mf_req = 1'b0;
  logic        mt_hi  = 1'b0;
  logic        mt_lo  = 1'b0;
  logic [63:0] mt_data = '0;
  logic        flush  = 1'b0;
  logic [63:0] hi, lo;
  logic        busy, done, stall;

  int n_cmp = 0;
  int n_bad = 0;

  core_ex_muldiv #(.XLEN(64), .STEPS_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mf_req(mf_req), .mt_hi(mt_hi), .mt_lo(mt_lo), .mt_data(mt_data),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] ehi;
    logic [63:0] elo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // start an op, then wait (bounded) for done; lat = sample index of done, -1 on timeout
  task automatic run_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int bcnt);
    int n;
    start = 1'b1; op = o; A = a; B = b;
    tick();
    start = 1'b0;
    n = 0; bcnt = 0; lat = -1;
    while (lat < 0 && n < 200) begin
      n++;
      if (busy) bcnt++;
      if (done) lat = n;
      if (lat < 0) tick();
    end
  endtask

  initial begin
    int lat, bcnt, n;
    logic seen;

    vecs[0]  = '{2'd1, 64'd7, 64'd6, 64'd0, 64'd42};
    vecs[1]  = '{2'd0, ONES, 64'd1, ONES, ONES};
    vecs[2]  = '{2'd1, ONES, 64'd1, 64'd0, ONES};
    vecs[3]  = '{2'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[4]  = '{2'd3, 64'd7, 64'd0, 64'd7, ONES};
    vecs[5]  = '{2'd2, MNEG, ONES, 64'd0, MNEG};
    vecs[6]  = '{2'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, ONES};
    vecs[7]  = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, ONES, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[8]  = '{2'd1, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    vecs[9]  = '{2'd3, 64'd100, 64'd7, 64'd2, 64'd14};
    vecs[10] = '{2'd2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[11] = '{2'd0, MNEG, ONES, 64'd0, MNEG};

    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'd66);
      chk($sformatf("v%0d_busycycles", i), 64'(bcnt), 64'd65);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].elo);
      tick();
      chk($sformatf("v%0d_done_once", i), {63'd0, done}, 64'd0);
    end

    // MTHI+MTLO together, then read with busy=0 (no stall)
    mt_hi = 1'b1; mt_lo = 1'b1; mt_data = 64'h1234;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b0;
    mf_req = 1'b1;
    #1;
    chk("mt_both_hi", hi, 64'h1234);
    chk("mt_both_lo", lo, 64'h1234);
    chk("mf_idle_stall", {63'd0, stall}, 64'd0);
    chk("mt_no_done", {63'd0, done}, 64'd0);
    mf_req = 1'b0;

    // interlock: mf_req from cycle 2 stalls until the FIX exit edge
    start = 1'b1; op = 2'd0; A = 64'd3; B = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    start = 1'b0;
    tick();
    mf_req = 1'b1;
    #1;
    n = 0; seen = 1'b0;
    while (busy && n < 200) begin
      if (!stall) seen = 1'b1;
      tick();
      n++;
    end
    chk("ilk_stall_held", {63'd0, seen}, 64'd0);
    chk("ilk_stall_cycles", 64'(n), 64'd64);
    chk("ilk_stall_released", {63'd0, stall}, 64'd0);
    chk("ilk_hi", hi, ONES);
    chk("ilk_lo", lo, 64'hFFFF_FFFF_FFFF_FFF4);
    mf_req = 1'b0;
    tick();

    // second start while busy is held, then accepted once busy drops
    start = 1'b1; op = 2'd1; A = 64'd2; B = 64'd3;
    tick();
    A = 64'd4; B = 64'd5;
    n = 0; seen = 1'b0;
    while (busy && n < 200) begin
      if (!stall) seen = 1'b1;
      tick();
      n++;
    end
    chk("hold_stall", {63'd0, seen}, 64'd0);
    chk("hold_stall_off", {63'd0, stall}, 64'd0);
    chk("hold_first_lo", lo, 64'd6);
    tick();
    chk("hold_accepted_busy", {63'd0, busy}, 64'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("hold_second_lat", 64'(n), 64'd65);
    chk("hold_second_lo", lo, 64'd20);
    tick();

    // flush mid-divide leaves hi/lo untouched and never pulses done
    mt_hi = 1'b1; mt_data = 64'h11;
    tick();
    mt_hi = 1'b0; mt_lo = 1'b1; mt_data = 64'h22;
    tick();
    mt_lo = 1'b0;
    start = 1'b1; op = 2'd2; A = 64'd100; B = 64'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (done) seen = 1'b1;
      tick();
    end
    chk("flush_no_done", {63'd0, seen}, 64'd0);
    chk("flush_hi", hi, 64'h11);
    chk("flush_lo", lo, 64'h22);

    // reset mid-operation clears outputs immediately
    start = 1'b1; op = 2'd1; A = ONES; B = ONES;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    mf_req = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    chk("rstmid_hi", hi, 64'd0);
    chk("rstmid_lo", lo, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);
    chk("rstmid_stall", {63'd0, stall}, 64'd0);
    mf_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_op(2'd1, 64'd3, 64'd5, lat, bcnt);
    chk("post_rst_lat", 64'(lat), 64'd66);
    chk("post_rst_lo", lo, 64'd15);
    chk("post_rst_hi", hi, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
